sd_ddr_burst_writer: RTL and testbench

- Sits directly downstream of the SD single-block reader.
- Collects each 32-bit word the reader strobes out, at one word per 32 SD clocks and with no backpressure.
- Buffers words in a small synchronous FIFO, then issues fixed-length write bursts to the DDR controller's user write port at incrementing word addresses.
- After one full picture frame is written it pulses frame_done and wraps the address back to the frame base.

---
 rtl/sd_ddr_pkg.sv | 23 ++
 rtl/sd_ddr_burst_writer_if.sv | 28 ++
 rtl/sd_sync_fifo.sv | 59 +++++
 rtl/sd_ddr_burst_writer.sv | 122 ++++++++++++
 tb/tb_sd_ddr_burst_writer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sd_ddr_pkg.sv
// Shared types and default parameters for the SD-to-DDR burst writer.
package sd_ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_DATA     = 2'd2,
    ST_WAIT_FIN = 2'd3
  } state_e;

  localparam int unsigned DEF_BURST_LEN   = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 64;
  localparam int unsigned DEF_ADDR_W      = 24;
  localparam int unsigned DEF_FRAME_WORDS = 393216;
  localparam logic [23:0] DEF_BASE_ADDR   = 24'd0;
  localparam int unsigned BURST_LEN_W     = 10;

  // SD stream is big-endian per word; DDR pixel order is little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_ddr_burst_writer_if.sv
// SD reader input strobe plus DDR controller user write port.
interface sd_ddr_burst_writer_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [31:0]       data_in;
  logic              data_valid;
  logic              wr_burst_req;
  logic [9:0]        wr_burst_len;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic              wr_burst_data_req;
  logic [31:0]       wr_burst_data;
  logic              wr_burst_finish;
  logic              frame_done;
  logic              fifo_overflow;
  logic              busy;

  modport master (
    input  data_in, data_valid, wr_burst_data_req, wr_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
           frame_done, fifo_overflow, busy
  );

  modport slave (
    output data_in, data_valid, wr_burst_data_req, wr_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
           frame_done, fifo_overflow, busy
  );
endinterface

// File: rtl/sd_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty/count.
module sd_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/sd_ddr_burst_writer.sv
// Buffers SD reader words and writes them to DDR in fixed bursts, wrapping per frame.
// Optional SD_BYTE_SWAP_EN: store each word byte-reversed (little-endian pixel order).
module sd_ddr_burst_writer
  import sd_ddr_pkg::*;
#(
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS
) (
  input logic            SD_clk,
  input logic            rst_n,
  sd_ddr_burst_writer_if.master bus
);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned WCNT_W = $clog2(FRAME_WORDS) + 1;

  state_e            state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic [ADDR_W-1:0] addr_nxt;
  logic              frame_done_nxt;
  logic              rd_en_c;
  logic [31:0]       wr_word;
  logic [31:0]       fifo_rd_data;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

`ifdef SD_BYTE_SWAP_EN
  assign wr_word = byte_swap32(bus.data_in);
`else
  assign wr_word = bus.data_in;
`endif

  sd_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (SD_clk),
    .rst_n   (rst_n),
    .wr_en   (bus.data_valid),
    .wr_data (wr_word),
    .rd_en   (rd_en_c & ~fifo_empty),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.wr_burst_data = fifo_rd_data;
  assign bus.wr_burst_len  = BURST_LEN_W'(BURST_LEN);

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    rd_en_c        = 1'b0;
    beat_nxt       = beat;
    addr_nxt       = bus.wr_burst_addr;
    wcnt_nxt       = wcnt;
    wcnt_inc       = wcnt + WCNT_W'(BURST_LEN);
    frame_done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count >= CNT_W'(BURST_LEN)) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.wr_burst_data_req) begin
          rd_en_c   = 1'b1;
          beat_nxt  = BEAT_W'(1);
          state_nxt = (BURST_LEN == 1) ? ST_WAIT_FIN : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.wr_burst_data_req) begin
          rd_en_c  = 1'b1;
          beat_nxt = beat + BEAT_W'(1);
          if (beat_nxt == BEAT_W'(BURST_LEN)) state_nxt = ST_WAIT_FIN;
        end
      end
      ST_WAIT_FIN: begin
        if (bus.wr_burst_finish) begin
          addr_nxt  = bus.wr_burst_addr + ADDR_W'(BURST_LEN);
          wcnt_nxt  = wcnt_inc;
          // Last burst of the frame: rewind to the frame base.
          if (wcnt_inc == WCNT_W'(FRAME_WORDS)) begin
            wcnt_nxt       = '0;
            addr_nxt       = BASE_ADDR;
            frame_done_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat              <= '0;
      wcnt              <= '0;
      bus.wr_burst_addr <= BASE_ADDR;
      bus.wr_burst_req  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.frame_done    <= 1'b0;
      bus.fifo_overflow <= 1'b0;
    end else begin
      beat              <= beat_nxt;
      wcnt              <= wcnt_nxt;
      bus.wr_burst_addr <= addr_nxt;
      bus.wr_burst_req  <= (state_nxt == ST_REQ);
      bus.busy          <= (state_nxt != ST_IDLE);
      bus.frame_done    <= frame_done_nxt;
      if (bus.data_valid && fifo_full) bus.fifo_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sd_ddr_burst_writer.sv
// Directed self-checking bench for sd_ddr_burst_writer (small frame, non-zero base).
module tb_sd_ddr_burst_writer;
  localparam logic [23:0] BASE = 24'h100;

  logic SD_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 SD_clk = ~SD_clk;

  sd_ddr_burst_writer_if #(.ADDR_W(24)) bus();

  sd_ddr_burst_writer #(
    .BURST_LEN   (16),
    .FIFO_DEPTH  (64),
    .ADDR_W      (24),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (64)
  ) dut (
    .SD_clk (SD_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_data = '0;

  function automatic logic [31:0] exp_word(input logic [31:0] v);
`ifdef SD_BYTE_SWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] v, input int gap);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_block(input logic [31:0] first);
    for (int i = 0; i < 16; i++) send_word(first + 32'(i), (i == 15) ? 0 : 31);
  endtask

  task automatic wait_req();
    int k = 0;
    while (!bus.wr_burst_req && k < 200) begin
      tick();
      k++;
    end
    chk("req_seen", 32'(bus.wr_burst_req), 32'd1);
  endtask

  task automatic run_burst(input logic [23:0] a, input bit gapped, input logic [31:0] first,
                           input bit fd, input bit extra_req);
    wait_req();
    chk("burst_addr", 32'(bus.wr_burst_addr), 32'(a));
    chk("burst_len", 32'(bus.wr_burst_len), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (gapped && i > 0) begin
        bus.wr_burst_data_req = 1'b0;
        tick();
        chk("data_hold", bus.wr_burst_data, last_data);
      end
      bus.wr_burst_data_req = 1'b1;
      tick();
      last_data = exp_word(first + 32'(i));
      chk("burst_data", bus.wr_burst_data, last_data);
      if (i == 0) chk("req_drop", 32'(bus.wr_burst_req), 32'd0);
    end
    bus.wr_burst_data_req = 1'b0;
    if (extra_req) begin
      bus.wr_burst_data_req = 1'b1;
      tick();
      bus.wr_burst_data_req = 1'b0;
      chk("extra_req_no_read", bus.wr_burst_data, last_data);
      chk("extra_req_busy", 32'(bus.busy), 32'd1);
    end
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    chk("frame_done_pulse", 32'(bus.frame_done), 32'(fd));
    chk("idle_after_fin", 32'(bus.busy), 32'd0);
    chk("next_addr", 32'(bus.wr_burst_addr), fd ? 32'(BASE) : 32'(a + 24'd16));
    tick();
    chk("frame_done_low", 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    bus.data_in           = '0;
    bus.data_valid        = 1'b0;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b0;
    repeat (3) tick();

    chk("rst_req", 32'(bus.wr_burst_req), 32'd0);
    chk("rst_addr", 32'(bus.wr_burst_addr), 32'(BASE));
    chk("rst_data", bus.wr_burst_data, 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_overflow", 32'(bus.fifo_overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Stream of 16 words; request appears two edges after the 16th strobe
    send_block(32'h0);
    chk("latency_req_low", 32'(bus.wr_burst_req), 32'd0);
    tick();
    chk("latency_req_high", 32'(bus.wr_burst_req), 32'd1);
    chk("latency_busy", 32'(bus.busy), 32'd1);
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    chk("fin_ignored_addr", 32'(bus.wr_burst_addr), 32'(BASE));
    chk("fin_ignored_req", 32'(bus.wr_burst_req), 32'd1);
    run_burst(BASE, 1'b0, 32'h0, 1'b0, 1'b0);

    // Gapped data_req plus a 17th request in WAIT_FIN
    send_block(32'h20);
    run_burst(BASE + 24'h10, 1'b1, 32'h20, 1'b0, 1'b1);

    // Finish the 64-word frame, then wrap to the base
    send_block(32'h30);
    run_burst(BASE + 24'h20, 1'b0, 32'h30, 1'b0, 1'b0);
    send_block(32'h40);
    run_burst(BASE + 24'h30, 1'b0, 32'h40, 1'b1, 1'b0);
    send_block(32'h60);
    run_burst(BASE, 1'b0, 32'h60, 1'b0, 1'b0);

    // Reset in the middle of a burst
    send_block(32'h70);
    wait_req();
    chk("mid_addr", 32'(bus.wr_burst_addr), 32'(BASE + 24'h10));
    for (int i = 0; i < 5; i++) begin
      bus.wr_burst_data_req = 1'b1;
      tick();
      chk("mid_data", bus.wr_burst_data, exp_word(32'h70 + 32'(i)));
    end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.wr_burst_req), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_addr", 32'(bus.wr_burst_addr), 32'(BASE));
    chk("async_rst_data", bus.wr_burst_data, 32'd0);
    bus.wr_burst_data_req = 1'b0;
    last_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    send_block(32'h11223344);
    run_burst(BASE, 1'b0, 32'h11223344, 1'b0, 1'b0);

    // Overflow: 65 back-to-back strobes with no data grants
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_data = '0;
    tick();
    for (int i = 0; i < 65; i++) begin
      send_word(32'(i), 0);
      if (i == 63) chk("ovf_not_yet", 32'(bus.fifo_overflow), 32'd0);
    end
    chk("ovf_set", 32'(bus.fifo_overflow), 32'd1);
    repeat (5) tick();
    chk("ovf_held", 32'(bus.fifo_overflow), 32'd1);
    for (int k = 0; k < 4; k++)
      run_burst(BASE + 24'(16 * k), 1'b0, 32'(16 * k), (k == 3), 1'b0);
    chk("ovf_sticky", 32'(bus.fifo_overflow), 32'd1);
    chk("fifo_drained_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
